// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit
//   Iterative multiply/divide unit that owns the architectural HI/LO registers.
//   MULT/MULTU/DIV/DIVU take WIDTH+1 cycles: WIDTH shift-add or restoring
//   shift-subtract steps on magnitudes, then one sign-fix cycle that writes
//   HI/LO and pulses done_o. MTHI/MTLO write HI/LO directly while idle.
//
// Ports
//   clk_i      clock, rising edge
//   rst_n_i    synchronous reset, active low
//   start_i    launch operation (sampled only when idle)
//   op_i       0=MULT 1=MULTU 2=DIV 3=DIVU
//   src_a_i    multiplicand / dividend
//   src_b_i    multiplier / divisor
//   cancel_i   abort in-flight operation; blocks a start while idle
//   mthi_i     write wdata_i to HI while idle
//   mtlo_i     write wdata_i to LO while idle
//   wdata_i    MTHI/MTLO data
//   busy_o     operation in flight
//   done_o     one-cycle pulse when HI/LO were written by a mul/div
//   hi_o/lo_o  HI / LO registers
//
// state  | meaning
// IDLE   | waiting; accepts start and MTHI/MTLO
// RUN    | one iteration step per cycle, counter counts down to 0
// FIX    | sign correction, HI/LO write, done pulse
module muldiv_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             cancel_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH:0]   div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Operands are reduced to magnitudes; 0x80000000 maps to itself, which is
  // the correct unsigned magnitude.
  always_comb begin
    a_neg = ~op_i[0] & src_a_i[WIDTH-1];
    b_neg = ~op_i[0] & src_b_i[WIDTH-1];
    abs_a = a_neg ? (WIDTH'(0) - src_a_i) : src_a_i;
    abs_b = b_neg ? (WIDTH'(0) - src_b_i) : src_b_i;
  end

  // acc_q low half holds the multiplier (mul) or the dividend/quotient (div);
  // high half holds the partial product or the partial remainder.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, divisor_q};
    mul_next  = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
    div_shift = {acc_q, 1'b0};
    div_diff  = div_shift[2*WIDTH:WIDTH] - {1'b0, divisor_q};
    div_next  = div_diff[WIDTH] ? div_shift[2*WIDTH-1:0]
                                : {div_diff[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};
  end

  // A zero divisor naturally yields remainder = |a|, so only the quotient
  // needs forcing to all ones; the remainder sign fix restores src_a.
  always_comb begin
    prod_fix = neg_q ? ((2*WIDTH)'(0) - acc_q) : acc_q;
    quo_fix  = div0_q ? {WIDTH{1'b1}}
             : (neg_q ? (WIDTH'(0) - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0]);
    rem_fix  = rem_neg_q ? (WIDTH'(0) - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    divisor_d = divisor_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i && !cancel_i) begin
          acc_d     = {{WIDTH{1'b0}}, abs_a};
          divisor_d = abs_b;
          is_div_d  = op_i[1];
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          div0_d    = (src_b_i == '0);
          cnt_d     = CW'(WIDTH - 1);
          state_d   = S_RUN;
        end else if (!start_i) begin
          // A start (even one blocked by cancel) drops any move in the same cycle.
          if (mthi_i) hi_d = wdata_i;
          if (mtlo_i) lo_d = wdata_i;
        end
      end
      S_RUN: begin
        if (cancel_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          if (cnt_q == '0) state_d = S_FIX;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!cancel_i) begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      divisor_q <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      divisor_q <= divisor_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
module tb_muldiv_hilo_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        cancel, mthi, mtlo;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  muldiv_hilo_unit #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .op_i(op),
    .src_a_i(src_a), .src_b_i(src_b), .cancel_i(cancel),
    .mthi_i(mthi), .mtlo_i(mtlo), .wdata_i(wdata),
    .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a one-cycle start; returns at the negedge after the accepting edge.
  task automatic do_start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count posedges until done is seen (sampled #1 after the edge), bounded.
  task automatic wait_done(output int cycles, output bit seen);
    cycles = 0; seen = 1'b0;
    while (!seen && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk); rst_n = 1'b0;
    step(2);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
    total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_multu;
    int c; bit s;
    do_start(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL multu_busy got=%b exp=1", busy); end
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL multu_hi_hold got=%h exp=0", hi); end
    wait_done(c, s);
    total++; if (!s || c != 33) begin bad++; $display("FAIL multu_latency got=%0d seen=%0b exp=33", c, s); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL multu_busy_end got=%b exp=0", busy); end
    total++; if (hi !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hi got=%h exp=fffffffe", hi); end
    total++; if (lo !== 32'h0000_0001) begin bad++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
    step(1);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL multu_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_signed;
    int c; bit s;
    do_start(2'd0, 32'hFFFF_FFFD, 32'd7);
    wait_done(c, s);
    total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
    total++; if (lo !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mult_lo got=%h exp=ffffffeb", lo); end
    do_start(2'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done(c, s);
    total++; if (!s || c != 33) begin bad++; $display("FAIL div_latency got=%0d seen=%0b exp=33", c, s); end
    total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
    total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
    do_start(2'd3, 32'd1000, 32'd7);
    wait_done(c, s);
    total++; if (lo !== 32'd142) begin bad++; $display("FAIL divu_lo got=%0d exp=142", lo); end
    total++; if (hi !== 32'd6) begin bad++; $display("FAIL divu_hi got=%0d exp=6", hi); end
  endtask

  task automatic test_corner_div;
    int c; bit s;
    do_start(2'd3, 32'd100, 32'd0);
    wait_done(c, s);
    total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divu0_lo got=%h exp=ffffffff", lo); end
    total++; if (hi !== 32'd100) begin bad++; $display("FAIL divu0_hi got=%h exp=00000064", hi); end
    do_start(2'd2, 32'hFFFF_FFF9, 32'd0);
    wait_done(c, s);
    total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div0_lo got=%h exp=ffffffff", lo); end
    total++; if (hi !== 32'hFFFF_FFF9) begin bad++; $display("FAIL div0_hi got=%h exp=fffffff9", hi); end
    do_start(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(c, s);
    total++; if (lo !== 32'h8000_0000) begin bad++; $display("FAIL divovf_lo got=%h exp=80000000", lo); end
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL divovf_hi got=%h exp=0", hi); end
  endtask

  task automatic test_ignored;
    int c; bit s;
    do_start(2'd3, 32'd9, 32'd3);
    // Second start plus mthi two cycles after the first start
    @(negedge clk);
    start = 1'b1; op = 2'd1; src_a = 32'd5; src_b = 32'd5; mthi = 1'b1; wdata = 32'h55;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    total++; if (hi === 32'h55) begin bad++; $display("FAIL busy_mthi got=%h exp=not 55", hi); end
    wait_done(c, s);
    total++; if (!s || c != 31) begin bad++; $display("FAIL ign_latency got=%0d seen=%0b exp=31", c, s); end
    total++; if (lo !== 32'd3) begin bad++; $display("FAIL ign_lo got=%0d exp=3", lo); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL ign_hi got=%0d exp=0", hi); end
    step(1);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_second_start got=%b exp=0", busy); end
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h55;
    // mthi/mtlo share wdata; use two cycles for distinct values
    @(negedge clk);
    mthi = 1'b0; wdata = 32'hAA;
    @(negedge clk);
    mtlo = 1'b0;
    #1;
    total++; if (hi !== 32'h55) begin bad++; $display("FAIL mthi got=%h exp=55", hi); end
    total++; if (lo !== 32'hAA) begin bad++; $display("FAIL mtlo got=%h exp=aa", lo); end
    // start and mthi together while idle: move is dropped
    @(negedge clk);
    start = 1'b1; op = 2'd1; src_a = 32'd2; src_b = 32'd3; mthi = 1'b1; wdata = 32'h77;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    wait_done(c, s);
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL start_wins_hi got=%h exp=0", hi); end
    total++; if (lo !== 32'd6) begin bad++; $display("FAIL start_wins_lo got=%h exp=6", lo); end
  endtask

  task automatic test_cancel;
    bit seen_done;
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h11;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    do_start(2'd0, 32'd5, 32'd6);
    step(19);
    @(negedge clk); cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cancel_busy got=%b exp=0", busy); end
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen_done = 1'b1;
      @(posedge clk); #1;
    end
    total++; if (seen_done) begin bad++; $display("FAIL cancel_done got=1 exp=0"); end
    total++; if (hi !== 32'h11 || lo !== 32'h11) begin bad++; $display("FAIL cancel_hilo got=%h/%h exp=11/11", hi, lo); end
    // cancel with start while idle: start not taken
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = 2'd1; src_a = 32'd4; src_b = 32'd4;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cancel_start got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid;
    do_start(2'd2, 32'd100, 32'd7);
    step(10);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    total++; if ({busy, done, hi, lo} !== 66'h0) begin bad++; $display("FAIL rst_mid got=%b %b %h %h exp=0", busy, done, hi, lo); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_back_to_back;
    int c; bit s;
    do_start(2'd1, 32'd3, 32'd4);
    wait_done(c, s);
    total++; if (lo !== 32'd12) begin bad++; $display("FAIL b2b_first_lo got=%0d exp=12", lo); end
    do_start(2'd1, 32'h0001_0000, 32'h0001_0000);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b exp=1", busy); end
    wait_done(c, s);
    total++; if (!s || c != 33) begin bad++; $display("FAIL b2b_latency got=%0d seen=%0b exp=33", c, s); end
    total++; if (hi !== 32'd1 || lo !== 32'd0) begin bad++; $display("FAIL b2b_result got=%h/%h exp=1/0", hi, lo); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'd0; src_a = '0; src_b = '0;
    cancel = 1'b0; mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    test_reset();
    test_multu();
    test_signed();
    test_corner_div();
    test_ignored();
    test_cancel();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
